// File: rtl/mfp_fft_pkg.sv
// Shared helpers for the mfp_fft engine: elaboration-time twiddle generation,
// fixed-point rounding, overflow handling and bit-reversed indexing.
package mfp_fft_pkg;

  localparam int AW = 64;
  typedef logic signed [AW-1:0] acc_t;

  localparam real PI = 3.14159265358979323846;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int bitrev(input int v, input int bits);
    int r;
    r = 0;
    for (int b = 0; b < bits; b++) begin
      if (((v >> b) & 1) != 0) r = r | (1 << (bits - 1 - b));
    end
    return r;
  endfunction

  // Taylor series keep twiddle generation free of math library calls.
  function automatic real cos_series(input real x);
    real sum, term;
    sum  = 1.0;
    term = 1.0;
    for (int i = 1; i < 24; i++) begin
      term = -term * x * x / (real'(2 * i - 1) * real'(2 * i));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic real sin_series(input real x);
    real sum, term;
    sum  = x;
    term = x;
    for (int i = 1; i < 24; i++) begin
      term = -term * x * x / (real'(2 * i) * real'(2 * i + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic acc_t to_fixed(input real r, input int frac);
    real s;
    s = r;
    for (int i = 0; i < frac; i++) s = s * 2.0;
    if (s >= 0.0) return acc_t'($rtoi(s + 0.5));
    return acc_t'($rtoi(s - 0.5));
  endfunction

  // Real part of e^(-+j2*pi*k/n); k is always below n/2.
  function automatic acc_t tw_re(input int k, input int n, input int frac);
    if (k == 0) return acc_t'(1) <<< frac;
    if (4 * k == n) return acc_t'(0);
    return to_fixed(cos_series(2.0 * PI * real'(k) / real'(n)), frac);
  endfunction

  function automatic acc_t tw_im(input int k, input int n, input int frac, input bit inv);
    acc_t s;
    if (k == 0) s = acc_t'(0);
    else if (4 * k == n) s = acc_t'(1) <<< frac;
    else s = to_fixed(sin_series(2.0 * PI * real'(k) / real'(n)), frac);
    return inv ? s : -s;
  endfunction

  // Drop sh fractional bits: floor, or nearest with ties away from zero.
  function automatic acc_t rnd_shift(input acc_t v, input int sh, input bit is_floor);
    acc_t half;
    if (sh == 0) return v;
    if (is_floor) return v >>> sh;
    half = acc_t'(1) <<< (sh - 1);
    if (v >= 0) return (v + half) >>> sh;
    return -((-v + half) >>> sh);
  endfunction

  function automatic acc_t sat_wrap(input acc_t v, input int w, input bit sat);
    acc_t hi, lo;
    hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
    lo = -hi - acc_t'(1);
    if (sat) begin
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
    end
    return (v <<< (AW - w)) >>> (AW - w);
  endfunction

endpackage

// File: rtl/mfp_butterfly.sv
// One radix-2 DIT butterfly with a constant twiddle: p = a + w*b, q = a - w*b,
// optionally halved for the inverse direction, then reduced to W bits.
module mfp_butterfly
  import mfp_fft_pkg::*;
#(
  parameter int W        = 8,
  parameter int FRAC     = 8,
  parameter bit Saturate = 1'b1,
  parameter bit isFloor  = 1'b0,
  parameter bit Halve    = 1'b0,
  parameter logic signed [W+1:0] TWR = '0,
  parameter logic signed [W+1:0] TWI = '0
) (
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  output logic signed [W-1:0] p_re,
  output logic signed [W-1:0] p_im,
  output logic signed [W-1:0] q_re,
  output logic signed [W-1:0] q_im
);

  acc_t ar, ai, br, bi, wr, wi, tr, ti, sr, si, dr, di;

  always_comb begin
    ar = acc_t'(a_re);
    ai = acc_t'(a_im);
    br = acc_t'(b_re);
    bi = acc_t'(b_im);
    wr = acc_t'(TWR);
    wi = acc_t'(TWI);
    // Full-precision complex product, rounded once back to the stage format.
    tr = rnd_shift(br * wr - bi * wi, FRAC, isFloor);
    ti = rnd_shift(br * wi + bi * wr, FRAC, isFloor);
    sr = ar + tr;
    si = ai + ti;
    dr = ar - tr;
    di = ai - ti;
    if (Halve) begin
      sr = rnd_shift(sr, 1, isFloor);
      si = rnd_shift(si, 1, isFloor);
      dr = rnd_shift(dr, 1, isFloor);
      di = rnd_shift(di, 1, isFloor);
    end
  end

  assign p_re = W'(sat_wrap(sr, W, Saturate));
  assign p_im = W'(sat_wrap(si, W, Saturate));
  assign q_re = W'(sat_wrap(dr, W, Saturate));
  assign q_im = W'(sat_wrap(di, W, Saturate));

endmodule

// File: rtl/mfp_fft.sv
// Fully parallel fixed-point radix-2 DIT FFT/iFFT: bit-reversed input wiring,
// log2(FFTL) butterfly columns, a register every pipeInterval columns, registered output.
module mfp_fft
  import mfp_fft_pkg::*;
#(
  parameter int FFTL         = 16,
  parameter int FFTW         = 8,
  parameter int InW          = 8,
  parameter bit Inverse      = 1'b0,
  parameter int pipeInterval = 4,
  parameter bit Saturate     = 1'b1,
  parameter bit isFloor      = 1'b0,
  localparam int IW = Inverse ? FFTW : InW,
  localparam int OW = Inverse ? InW : FFTW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [FFTL*IW-1:0]   ReIn,
  input  logic [FFTL*IW-1:0]   ImIn,
  output logic [FFTL*OW-1:0]   ReOut,
  output logic [FFTL*OW-1:0]   ImOut
);

  localparam int S  = clog2(FFTL);
  localparam int F  = FFTW - InW;
  localparam int NW = FFTL * FFTW;

  // lv_*[s] is the frame entering butterfly column s; lv_*[S] feeds the output stage.
  wire [NW-1:0] lv_re [S+1];
  wire [NW-1:0] lv_im [S+1];
  wire [FFTL*OW-1:0] out_re, out_im;

  for (genvar i = 0; i < FFTL; i++) begin : g_in
    localparam int R = bitrev(i, S);
    if (Inverse) begin : g_inv
      assign lv_re[0][i*FFTW +: FFTW] = ReIn[R*IW +: IW];
      assign lv_im[0][i*FFTW +: FFTW] = ImIn[R*IW +: IW];
    end else begin : g_fwd
      // Integer samples move into the frequency-domain format.
      assign lv_re[0][i*FFTW +: FFTW] = FFTW'(signed'(ReIn[R*IW +: IW])) << F;
      assign lv_im[0][i*FFTW +: FFTW] = FFTW'(signed'(ImIn[R*IW +: IW])) << F;
    end
  end

  for (genvar s = 0; s < S; s++) begin : g_stage
    localparam int HALF = 1 << s;
    wire [NW-1:0] yr, yi;

    for (genvar b = 0; b < FFTL / 2; b++) begin : g_bf
      localparam int J   = b % HALF;
      localparam int TOP = (b / HALF) * 2 * HALF + J;
      localparam int BOT = TOP + HALF;
      localparam int K   = J * (FFTL / (2 * HALF));
      localparam logic signed [FFTW+1:0] TWR = (FFTW+2)'(tw_re(K, FFTL, FFTW));
      localparam logic signed [FFTW+1:0] TWI = (FFTW+2)'(tw_im(K, FFTL, FFTW, Inverse));

      mfp_butterfly #(
        .W        (FFTW),
        .FRAC     (FFTW),
        .Saturate (Saturate),
        .isFloor  (isFloor),
        .Halve    (Inverse),
        .TWR      (TWR),
        .TWI      (TWI)
      ) u_bf (
        .a_re (lv_re[s][TOP*FFTW +: FFTW]),
        .a_im (lv_im[s][TOP*FFTW +: FFTW]),
        .b_re (lv_re[s][BOT*FFTW +: FFTW]),
        .b_im (lv_im[s][BOT*FFTW +: FFTW]),
        .p_re (yr[TOP*FFTW +: FFTW]),
        .p_im (yi[TOP*FFTW +: FFTW]),
        .q_re (yr[BOT*FFTW +: FFTW]),
        .q_im (yi[BOT*FFTW +: FFTW])
      );
    end

    // The last group's register is the output register, so no stage register there.
    if (((s + 1) % pipeInterval == 0) && (s < S - 1)) begin : g_reg
      logic [NW-1:0] qr, qi;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          qr <= '0;
          qi <= '0;
        end else if (en) begin
          qr <= yr;
          qi <= yi;
        end
      end
      assign lv_re[s+1] = qr;
      assign lv_im[s+1] = qi;
    end else begin : g_comb
      assign lv_re[s+1] = yr;
      assign lv_im[s+1] = yi;
    end
  end

  for (genvar i = 0; i < FFTL; i++) begin : g_out
    if (Inverse) begin : g_inv
      // Drop the F fractional bits to return to integer samples.
      assign out_re[i*OW +: OW] = OW'(sat_wrap(rnd_shift(acc_t'(signed'(lv_re[S][i*FFTW +: FFTW])),
                                                          F, isFloor), OW, Saturate));
      assign out_im[i*OW +: OW] = OW'(sat_wrap(rnd_shift(acc_t'(signed'(lv_im[S][i*FFTW +: FFTW])),
                                                          F, isFloor), OW, Saturate));
    end else begin : g_fwd
      assign out_re[i*OW +: OW] = lv_re[S][i*FFTW +: FFTW];
      assign out_im[i*OW +: OW] = lv_im[S][i*FFTW +: FFTW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ReOut <= '0;
      ImOut <= '0;
    end else if (en) begin
      ReOut <= out_re;
      ImOut <= out_im;
    end
  end

endmodule

// File: tb/tb_mfp_fft.sv
// Directed bench for mfp_fft: forward instance, inverse instance chained to it,
// and a wrapping forward instance, all at the default 16-point / 8-bit setting.
module tb_mfp_fft;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int NW = N * W;
  localparam real PI = 3.14159265358979323846;

  logic clk, rst_n, en;
  logic [NW-1:0] re_in, im_in;
  logic [NW-1:0] f_re, f_im, i_re, i_im, w_re, w_im;

  int n_cmp, n_mis;
  int xr[N], er[N], ei[N], zr[N];

  mfp_fft #(.Inverse(1'b0), .Saturate(1'b1)) u_fwd (
    .clk(clk), .rst_n(rst_n), .en(en),
    .ReIn(re_in), .ImIn(im_in), .ReOut(f_re), .ImOut(f_im)
  );

  mfp_fft #(.Inverse(1'b1), .Saturate(1'b1)) u_inv (
    .clk(clk), .rst_n(rst_n), .en(en),
    .ReIn(f_re), .ImIn(f_im), .ReOut(i_re), .ImOut(i_im)
  );

  mfp_fft #(.Inverse(1'b0), .Saturate(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en),
    .ReIn(re_in), .ImIn(im_in), .ReOut(w_re), .ImOut(w_im)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input int got, input int exp, input int tol);
    n_cmp++;
    if ((got - exp > tol) || (exp - got > tol)) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int elem(input logic [NW-1:0] v, input int i);
    logic signed [W-1:0] t;
    t = v[i*W +: W];
    return int'(t);
  endfunction

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  // driver
  task automatic set_frame(input int x[N]);
    for (int i = 0; i < N; i++) begin
      re_in[i*W +: W] = W'(x[i]);
      im_in[i*W +: W] = '0;
    end
  endtask

  task automatic check_frame(input string tag, input logic [NW-1:0] vr, input logic [NW-1:0] vi,
                             input int exr[N], input int exi[N], input int tol);
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("%s_re%0d", tag, i), elem(vr, i), exr[i], tol);
      check_val($sformatf("%s_im%0d", tag, i), elem(vi, i), exi[i], tol);
    end
  endtask

  task automatic dft_ref(input int x[N], output int r[N], output int im[N]);
    real sr, si, ang;
    for (int k = 0; k < N; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < N; n++) begin
        ang = 2.0 * PI * real'(n) * real'(k) / real'(N);
        sr = sr + real'(x[n]) * $cos(ang);
        si = si - real'(x[n]) * $sin(ang);
      end
      r[k]  = rnd(sr);
      im[k] = rnd(si);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    re_in = '0;
    im_in = '0;
    for (int i = 0; i < N; i++) zr[i] = 0;

    @(negedge clk);
    check_val("rst_fwd", elem(f_re, 0), 0, 0);
    check_val("rst_inv", elem(i_re, 0), 0, 0);
    check_val("rst_wrap", elem(w_re, 0), 0, 0);
    rst_n = 1'b1;

    // impulse: flat spectrum, inverse recovers the impulse
    for (int i = 0; i < N; i++) xr[i] = (i == 0) ? 4 : 0;
    set_frame(xr);
    #1 check_val("out_is_registered", elem(f_re, 0), 0, 0);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin er[i] = 4; ei[i] = 0; end
    check_frame("imp_fwd", f_re, f_im, er, ei, 0);
    @(negedge clk);
    check_frame("imp_inv", i_re, i_im, xr, zr, 0);

    // constant: DC only
    for (int i = 0; i < N; i++) xr[i] = 4;
    set_frame(xr);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin er[i] = (i == 0) ? 64 : 0; ei[i] = 0; end
    check_frame("const_fwd", f_re, f_im, er, ei, 0);
    @(negedge clk);
    check_frame("const_inv", i_re, i_im, xr, zr, 0);

    // seven-sample pulse against a double-precision DFT
    for (int i = 0; i < N; i++) xr[i] = (i < 7) ? 4 : 0;
    set_frame(xr);
    dft_ref(xr, er, ei);
    @(negedge clk);
    check_val("pulse_x0_exact", elem(f_re, 0), 28, 0);
    check_frame("pulse_fwd", f_re, f_im, er, ei, 1);
    @(negedge clk);
    check_frame("pulse_inv", i_re, i_im, xr, zr, 1);

    // overflow: clamp versus wrap
    for (int i = 0; i < N; i++) xr[i] = 100;
    set_frame(xr);
    @(negedge clk);
    check_val("sat_x0", elem(f_re, 0), 127, 0);
    check_val("sat_x1", elem(f_re, 1), 0, 0);
    check_val("sat_x0_im", elem(f_im, 0), 0, 0);
    check_val("wrap_x0", elem(w_re, 0), 64, 0);
    check_val("wrap_x1", elem(w_re, 1), 0, 0);

    // clock enable hold
    for (int i = 0; i < N; i++) xr[i] = (i == 0) ? 4 : 0;
    set_frame(xr);
    @(negedge clk);
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int j = 0; j < N; j++) xr[j] = (c * 7 + j * 5) % 50;
      set_frame(xr);
      @(negedge clk);
      check_val($sformatf("hold%0d_fwd0", c), elem(f_re, 0), 4, 0);
      check_val($sformatf("hold%0d_fwd5", c), elem(f_re, 5), 4, 0);
      check_val($sformatf("hold%0d_inv3", c), elem(i_re, 3), 8, 0);
    end
    en = 1'b1;
    for (int i = 0; i < N; i++) xr[i] = 4;
    set_frame(xr);
    @(negedge clk);
    check_val("en_resume_x0", elem(f_re, 0), 64, 0);
    check_val("en_resume_x3", elem(f_re, 3), 0, 0);

    // asynchronous reset in mid-cycle
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_fwd", elem(f_re, 0), 0, 0);
    check_val("arst_inv", elem(i_re, 0), 0, 0);
    check_val("arst_wrap", elem(w_re, 0), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) xr[i] = (i == 0) ? 4 : 0;
    set_frame(xr);
    #1 check_val("post_rst_wait", elem(f_re, 0), 0, 0);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin er[i] = 4; ei[i] = 0; end
    check_frame("post_rst_fwd", f_re, f_im, er, ei, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
